block_scroll_scheduler: RTL and testbench
=========================================

Name: block_scroll_scheduler

Overview:
Controls the obstacle pipeline in Flappy Bird. It sequences the scroll-tick counter through a game state machine (idle/run/pause/over). It emits the one-cycle shift tick that moves the pipe blocks and a spawn pulse with a pseudo-random gap row for each new pipe. The scroll period shortens as the player passes pipes, which raises game speed in levels.

Parameters:
WIDTH, 10, tick counter width; BASE_PERIOD must be no greater than 2**WIDTH
BASE_PERIOD, 1024, clocks per shift tick at level 0
PERIOD_STEP, 128, period reduction per speed level
MAX_LEVEL, 4, saturating maximum speed level; requires BASE_PERIOD - MAX_LEVEL*PERIOD_STEP >= 2
SPAWN_TICKS, 4, shift ticks between spawn pulses
LEVEL_PIPES, 5, passed pipes per level increment
LFSR_SEED, 8'hA5, LFSR reset value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; begins or restarts a game
pause  input  1  pulse; toggles RUN and PAUSE
collide  input  1  pulse; bird hit a pipe or ground
pipe_passed  input  1  pulse; bird cleared a pipe
shift_tick  output  1  one-cycle pulse; pipe blocks shift one column
spawn  output  1  one-cycle pulse, coincident with a shift_tick; load a new pipe
gap_row  output  3  gap position for the new pipe; valid while spawn=1
speed_level  output  3  current level, 0..MAX_LEVEL
running  output  1  high in RUN
game_over  output  1  high in OVER

Behaviour:
- FSM states: IDLE, RUN, PAUSE, OVER. Reset drives state to IDLE, all counters to 0, LFSR to LFSR_SEED, and speed_level, shift_tick, spawn, running and game_over to 0.
- Reset asserted mid-game returns the block to IDLE immediately (asynchronous).
- Transitions:
  - IDLE --start--> RUN.
  - RUN --collide--> OVER. collide has priority over pause in the same cycle.
  - RUN --pause--> PAUSE.
  - PAUSE --pause--> RUN. collide and pipe_passed are ignored in PAUSE.
  - OVER --start--> RUN.
  - start in RUN or PAUSE is ignored.
- Entering RUN from IDLE or OVER clears the tick counter, spawn count, pass count and speed_level, and latches period_cur = BASE_PERIOD. The LFSR is not cleared.
- Tick counter:
  - Counts only in RUN; it is frozen in PAUSE and held at 0 in IDLE and OVER.
  - shift_tick = (state==RUN) && (cycle >= period_cur-1) && !collide. This is combinational from registered state.
  - On shift_tick the counter wraps to 0 and period_cur reloads to BASE_PERIOD - speed_level*PERIOD_STEP.
  - A level change therefore takes effect from the next tick interval.
  - The first shift_tick after entering RUN is in the BASE_PERIOD-th RUN cycle. Subsequent ticks are exactly period_cur cycles apart.
  - Resuming from PAUSE continues the count with no lost or extra cycles.
- Spawn:
  - A spawn counter increments on each shift_tick.
  - spawn=1 on the shift_tick that brings it to SPAWN_TICKS; the counter then returns to 0.
  - The first spawn is on the SPAWN_TICKS-th tick.
  - gap_row = lfsr[2:0] in the spawn cycle. The LFSR advances after each spawn.
- LFSR: 8-bit, shift left, new bit0 = q7^q5^q4^q3.
- Levels:
  - pipe_passed in RUN increments the pass count.
  - When the count reaches LEVEL_PIPES, it clears and speed_level increments, saturating at MAX_LEVEL. At saturation the count still clears.
  - pipe_passed coincident with collide is not counted.
- Outputs: running = (state==RUN); game_over = (state==OVER). Both are registered-state decodes.

Decomposition:
- Package flappy_pkg holds:
  - the state enum typedef game_state_t (IDLE, RUN, PAUSE, OVER);
  - the LFSR tap constant;
  - localparam GAP_ROW_W = 3.
- Sub-module period_ticker: a loadable period counter with enable and clear, exposing the tick output and a period_cur load. The FSM, spawn, LFSR and level logic stay in the top module.

Test Plan:
Benches use BASE_PERIOD=16, PERIOD_STEP=2, MAX_LEVEL=4, SPAWN_TICKS=4, LEVEL_PIPES=5.
1. Reset then start -> running=1; shift_tick high in the 16th RUN cycle and every 16 cycles after; spawn on the 4th tick with gap_row=3'b101.
2. Pause pulse at RUN cycle 10, hold 20 cycles, pause again -> no ticks while paused; next tick 6 RUN cycles after resume.
3. Five pipe_passed pulses -> speed_level=1; tick interval becomes 14 from the tick after the level change. 30 passes -> speed_level saturates at 4, interval 8.
4. collide coincident with a would-be tick and with pause -> no shift_tick; state OVER; game_over=1; running=0; counters frozen.
5. start in OVER -> RUN with speed_level=0 and interval 16. The next gap_row continues the LFSR sequence and is not reseeded to 3'b101.
6. Asynchronous reset asserted between clock edges mid-RUN -> all outputs 0 and state IDLE immediately. start ignored in RUN; start in IDLE after reset restarts the game.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird obstacle scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} game_state_t;

    // Feedback taps q7, q5, q4, q3 of the 8-bit gap-row LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int GAP_ROW_W = 3;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/period_ticker.sv
// Loadable period counter: tick in the last cycle of each period, then reload.
// Latency: tick is combinational from registered count; reload takes effect next cycle.
// Backpressure: none; en freezes the count, clr restarts at BASE_PERIOD.
module period_ticker #(
    parameter int WIDTH       = 10,
    parameter int BASE_PERIOD = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           clr,
    input  logic [WIDTH:0] load_period,
    output logic           tick
);

    logic [WIDTH-1:0] cycle;
    // One bit wider than the count so a full 2**WIDTH period is representable.
    logic [WIDTH:0]   period_cur;

    assign tick = en && ({1'b0, cycle} >= period_cur - (WIDTH+1)'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle      <= '0;
            period_cur <= (WIDTH+1)'(BASE_PERIOD);
        end else if (clr) begin
            cycle      <= '0;
            period_cur <= (WIDTH+1)'(BASE_PERIOD);
        end else if (tick) begin
            cycle      <= '0;
            period_cur <= load_period;
        end else if (en) begin
            cycle      <= cycle + WIDTH'(1);
        end
    end

endmodule

// File: rtl/block_scroll_scheduler.sv
// Game FSM driving pipe scroll ticks, spawn pulses with LFSR gap rows, and speed levels.
// Latency: shift_tick/spawn/gap_row combinational from registered state; level updates next cycle.
// Backpressure: none; single-cycle pulse inputs are sampled every clock.
module block_scroll_scheduler
    import flappy_pkg::*;
#(
    parameter int         WIDTH       = 10,
    parameter int         BASE_PERIOD = 1024,
    parameter int         PERIOD_STEP = 128,
    parameter int         MAX_LEVEL   = 4,
    parameter int         SPAWN_TICKS = 4,
    parameter int         LEVEL_PIPES = 5,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 collide,
    input  logic                 pipe_passed,
    output logic                 shift_tick,
    output logic                 spawn,
    output logic [GAP_ROW_W-1:0] gap_row,
    output logic [2:0]           speed_level,
    output logic                 running,
    output logic                 game_over
);

    localparam int SPW = $clog2(SPAWN_TICKS + 1);
    localparam int PSW = $clog2(LEVEL_PIPES + 1);

    game_state_t    state;
    logic [SPW-1:0] spawn_cnt;
    logic [PSW-1:0] pass_cnt;
    logic [7:0]     lfsr;
    logic [WIDTH:0] reload;
    logic           tick_en;
    logic           tick_clr;
    logic           start_run;
    logic           pass_ok;

    // A collide cycle never ticks, so the pipes freeze exactly where the bird hit.
    assign tick_en   = (state == RUN) && !collide;
    assign tick_clr  = (state == IDLE) || (state == OVER);
    assign start_run = start && tick_clr;
    assign pass_ok   = (state == RUN) && pipe_passed && !collide;
    assign reload    = (WIDTH+1)'(BASE_PERIOD - int'(speed_level) * PERIOD_STEP);

    period_ticker #(
        .WIDTH       (WIDTH),
        .BASE_PERIOD (BASE_PERIOD)
    ) u_ticker (
        .clk         (clk),
        .reset       (reset),
        .en          (tick_en),
        .clr         (tick_clr),
        .load_period (reload),
        .tick        (shift_tick)
    );

    assign spawn     = shift_tick && (spawn_cnt == SPW'(SPAWN_TICKS - 1));
    assign gap_row   = lfsr[GAP_ROW_W-1:0];
    assign running   = (state == RUN);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            spawn_cnt   <= '0;
            pass_cnt    <= '0;
            speed_level <= '0;
            lfsr        <= LFSR_SEED;
        end else begin
            case (state)
                IDLE, OVER: if (start) state <= RUN;
                RUN: begin
                    if (collide)    state <= OVER;
                    else if (pause) state <= PAUSE;
                end
                PAUSE:      if (pause) state <= RUN;
                default:    state <= IDLE;
            endcase

            // A new game restarts the level schedule but keeps the LFSR running.
            if (start_run) begin
                spawn_cnt   <= '0;
                pass_cnt    <= '0;
                speed_level <= '0;
            end else begin
                if (shift_tick)
                    spawn_cnt <= spawn ? '0 : spawn_cnt + SPW'(1);
                if (spawn)
                    lfsr <= lfsr_next(lfsr);
                if (pass_ok) begin
                    if (pass_cnt == PSW'(LEVEL_PIPES - 1)) begin
                        pass_cnt <= '0;
                        if (speed_level < 3'(MAX_LEVEL))
                            speed_level <= speed_level + 3'd1;
                    end else begin
                        pass_cnt <= pass_cnt + PSW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_block_scroll_scheduler.sv
// Scoreboard bench for block_scroll_scheduler: expected ticks queued by stimulus, popped by monitor.
module tb_block_scroll_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       collide = 1'b0;
    logic       pipe_passed = 1'b0;
    logic       shift_tick;
    logic       spawn;
    logic [2:0] gap_row;
    logic [2:0] speed_level;
    logic       running;
    logic       game_over;

    block_scroll_scheduler #(
        .WIDTH       (5),
        .BASE_PERIOD (16),
        .PERIOD_STEP (2),
        .MAX_LEVEL   (4),
        .SPAWN_TICKS (4),
        .LEVEL_PIPES (5),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .collide     (collide),
        .pipe_passed (pipe_passed),
        .shift_tick  (shift_tick),
        .spawn       (spawn),
        .gap_row     (gap_row),
        .speed_level (speed_level),
        .running     (running),
        .game_over   (game_over)
    );

    typedef struct {
        int         cyc;
        bit         spawn;
        logic [2:0] gap;
    } tick_t;

    tick_t      sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_spc = 0;
    logic [7:0] exp_lfsr = 8'hA5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected tick at cycle c; every 4th tick since game start spawns with the LFSR's low bits.
    task automatic exp_tick(input int c);
        tick_t e;
        e.cyc   = c;
        e.spawn = 1'b0;
        e.gap   = 3'b000;
        exp_spc++;
        if (exp_spc == 4) begin
            e.spawn  = 1'b1;
            e.gap    = exp_lfsr[2:0];
            exp_lfsr = {exp_lfsr[6:0], exp_lfsr[7] ^ exp_lfsr[5] ^ exp_lfsr[4] ^ exp_lfsr[3]};
            exp_spc  = 0;
        end
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    always @(negedge clk) begin : monitor
        tick_t e;
        if (shift_tick === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick at cyc %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("tick_cyc", cyc, e.cyc);
                check("tick_spawn", spawn, e.spawn);
                if (e.spawn) check("gap_row", gap_row, e.gap);
            end
        end else if (spawn === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spawn_without_tick: got spawn=1 at cyc %0d expected 0", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int t1;
        int t2;
        int a;
        int base2;
        int base3;

        step(2);
        check("rst_running", running, 0);
        check("rst_game_over", game_over, 0);
        check("rst_speed", speed_level, 0);
        check("rst_tick", shift_tick, 0);
        check("rst_spawn", spawn, 0);
        reset = 1'b0;
        step(2);

        // Start: ticks every 16, spawn with gap 101 on the 4th
        start = 1'b1;
        step(1);
        start = 1'b0;
        base = cyc;
        check("run_running", running, 1);
        check("run_game_over", game_over, 0);
        for (int k = 0; k < 4; k++) exp_tick(base + 15 + 16 * k);
        t1 = base + 63;

        // Pause at RUN cycle 10 of the interval for 20 cycles
        exp_tick(t1 + 37);
        wait_until(t1 + 10);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        check("pause_running", running, 0);
        wait_until(t1 + 31);
        check("paused_running", running, 0);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        check("resume_running", running, 1);
        t2 = t1 + 37;

        // Levels: five passes -> level 1, then 30 more saturate at 4
        a = t2 + 16;
        exp_tick(a);
        exp_tick(a + 14);
        exp_tick(a + 26);
        exp_tick(a + 36);
        exp_tick(a + 44);
        exp_tick(a + 52);
        exp_tick(a + 60);
        wait_until(t2 + 1);
        for (int i = 0; i < 5; i++) begin
            pipe_passed = 1'b1;
            step(1);
            pipe_passed = 1'b0;
            step(1);
        end
        check("level_one", speed_level, 1);
        wait_until(a + 1);
        for (int i = 0; i < 30; i++) begin
            pipe_passed = 1'b1;
            step(1);
            pipe_passed = 1'b0;
            step(1);
        end
        check("level_sat", speed_level, 4);

        // Collide together with pause and a would-be tick
        wait_until(a + 68);
        collide = 1'b1;
        pause = 1'b1;
        pipe_passed = 1'b1;
        step(1);
        collide = 1'b0;
        pause = 1'b0;
        pipe_passed = 1'b0;
        check("over_game_over", game_over, 1);
        check("over_running", running, 0);
        check("over_speed", speed_level, 4);
        step(40);
        check("over_hold", game_over, 1);

        // Restart from OVER: level 0, interval 16, LFSR continues
        exp_spc = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        base2 = cyc;
        check("restart_running", running, 1);
        check("restart_speed", speed_level, 0);
        check("restart_game_over", game_over, 0);
        for (int k = 0; k < 5; k++) exp_tick(base2 + 15 + 16 * k);
        wait_until(base2 + 70);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_in_run", running, 1);

        // Async reset between edges on a would-be tick cycle
        wait_until(base2 + 95);
        #2;
        reset = 1'b1;
        #1;
        check("areset_running", running, 0);
        check("areset_game_over", game_over, 0);
        check("areset_tick", shift_tick, 0);
        check("areset_spawn", spawn, 0);
        check("areset_speed", speed_level, 0);
        exp_lfsr = 8'hA5;
        exp_spc = 0;
        step(2);
        reset = 1'b0;
        step(1);
        check("idle_running", running, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        base3 = cyc;
        check("reset_restart_running", running, 1);
        for (int k = 0; k < 4; k++) exp_tick(base3 + 15 + 16 * k);
        wait_until(base3 + 70);
        check("pending_ticks", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
